// File: rtl/store_merge_arbiter.sv
// store_merge_arbiter: round-robin store arbiter feeding a registered merge-buffer port,
// with a fence sequencer that drains, flushes and waits for the merge buffer before acking.
module store_merge_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*32-1:0]  req_addr,
   input  logic [NREQ*32-1:0]  req_wdata,
   input  logic [NREQ*4-1:0]   req_wstrb,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ-1:0]     fence_req,
   output logic [NREQ-1:0]     fence_ack,
   output logic                wmb_valid,
   output logic [31:0]         wmb_addr,
   output logic [31:0]         wmb_wdata,
   output logic [3:0]          wmb_wstrb,
   input  logic                wmb_ready,
   output logic                wmb_flush,
   input  logic                wmb_busy
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, WAIT, ACK} state_t;
   state_t state;
   logic [PW-1:0] rr_ptr, win, idx, fsel, fidx;
   logic any, grant;
   always_comb begin
      win = rr_ptr;
      idx = rr_ptr;
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req_valid[idx]) begin
            win = idx;
            any = 1'b1;
         end
         idx = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
      end
   end
   always_comb begin
      fsel = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (fence_req[k]) fsel = PW'(k);
   end
   // any pending fence, even one not yet latched, blocks store grants
   assign grant = any && (!wmb_valid || wmb_ready) && state == IDLE && !(|fence_req);
   assign req_ready = grant ? NREQ'(1) << win : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         wmb_valid <= 1'b0;
         wmb_addr  <= '0;
         wmb_wdata <= '0;
         wmb_wstrb <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         wmb_valid <= 1'b1;
         wmb_addr  <= req_addr[win*32 +: 32];
         wmb_wdata <= req_wdata[win*32 +: 32];
         wmb_wstrb <= req_wstrb[win*4 +: 4];
         rr_ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end else if (wmb_ready) begin
         wmb_valid <= 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fidx      <= '0;
         wmb_flush <= 1'b0;
         fence_ack <= '0;
      end else begin
         wmb_flush <= 1'b0;
         fence_ack <= '0;
         case (state)
            IDLE:
               if (|fence_req) begin
                  state <= DRAIN;
                  fidx  <= fsel;
               end
            DRAIN:
               if (!wmb_valid) begin
                  state     <= FLUSH;
                  wmb_flush <= 1'b1;
               end
            FLUSH: state <= WAIT;
            WAIT:
               if (!wmb_busy) begin
                  state     <= ACK;
                  fence_ack <= NREQ'(1) << fidx;
               end
            ACK: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/store_merge_arbiter.md
STORE_MERGE_ARBITER -- requirements
Module: store_merge_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of store requesters; legal values 2..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on clk rising edge.
REQ-004 req_valid  input  NREQ  per-requester store valid.
REQ-005 req_addr  input  NREQ*32  per-requester byte address; slice i is bits [32i+31:32i].
REQ-006 req_wdata  input  NREQ*32  per-requester store data, same slicing as req_addr.
REQ-007 req_wstrb  input  NREQ*4  per-requester byte strobes; slice i is bits [4i+3:4i].
REQ-008 req_ready  output  NREQ  per-requester accept; a store transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 fence_req  input  NREQ  per-requester fence (MEMBAR) request; level, held until acked.
REQ-010 fence_ack  output  NREQ  one-cycle pulse completing the fence of that requester.
REQ-011 wmb_valid, wmb_addr[31:0], wmb_wdata[31:0], wmb_wstrb[3:0]  output  store toward the merge buffer.
REQ-012 wmb_ready  input  1  merge-buffer accept.
REQ-013 wmb_flush  output  1  one-cycle flush request to the merge buffer.
REQ-014 wmb_busy  input  1  merge buffer holds data or is draining.

Function
REQ-015 The block SHALL hold a single-entry output register driving wmb_valid/addr/wdata/wstrb directly; no combinational path from req_* to wmb_*.
REQ-016 The output register SHALL be loadable when empty, or when wmb_valid and wmb_ready are both high in the same cycle (back-to-back, one store per cycle sustained).
REQ-017 Store grant SHALL be round-robin: search starts at rr_ptr; first i with req_valid[i] wins; on grant rr_ptr becomes (winner+1) mod NREQ.
REQ-018 At most one req_ready bit SHALL be high per cycle; req_ready[i] SHALL be high only for the round-robin winner when the output register is loadable and fence FSM is IDLE with no fence_req asserted.
REQ-019 req_ready SHALL NOT depend on wmb_ready except via the REQ-016 loadable term.
REQ-020 Zero-strobe stores (wstrb=0) SHALL be accepted and forwarded unchanged.
REQ-021 Fence FSM states: IDLE, DRAIN, FLUSH, WAIT, ACK.
REQ-022 IDLE->DRAIN when any fence_req is high; served requester fidx = lowest index with fence_req set, latched.
REQ-023 DRAIN: no store grants; ->FLUSH when the output register is empty (including the emptying cycle being complete).
REQ-024 FLUSH: wmb_flush=1 for exactly one cycle; ->WAIT.
REQ-025 WAIT: ->ACK on the first cycle with wmb_busy=0, no earlier than the cycle after FLUSH.
REQ-026 ACK: fence_ack[fidx]=1 for exactly one cycle; ->IDLE. Other pending fences are served in subsequent passes, lowest index first.
REQ-027 Stores from all requesters SHALL be blocked from DRAIN through ACK inclusive; store grants resume the cycle after ACK if no fence_req is pending.
REQ-028 A fence_req deasserted before ack SHALL NOT abort an in-progress fence sequence; the ack is still issued.
REQ-029 Simultaneous fence_req and req_valid from different requesters in IDLE: the fence wins; no store is granted that cycle.

Reset
REQ-030 On rst: output register empty, wmb_valid=0, wmb_addr/wdata/wstrb=0, wmb_flush=0, req_ready=0, fence_ack=0, rr_ptr=0, FSM=IDLE.
REQ-031 rst asserted mid-operation SHALL discard the held store and any in-progress fence without an ack; outputs reach reset values the cycle after rst is sampled.

Verification
REQ-032 Req0..3 all valid continuously, wmb_ready=1 -> grants 0,1,2,3,0 in consecutive cycles; wmb_valid is continuously 1 from cycle 1.
REQ-033 Req1 store addr 0x100 data 0xA5A5A5A5 wstrb 0xF, wmb_ready=0 for 3 cycles -> wmb_* holds 0x100/0xA5A5A5A5/0xF stable; req_ready all 0 while held; transfer on the first cycle wmb_ready=1.
REQ-034 Held store pending, fence_req[2]=1, wmb_busy=1 for 5 cycles after flush -> wmb_flush pulses once only after the store transfers; fence_ack[2] pulses one cycle after wmb_busy falls; no store grants in between.
REQ-035 fence_req[3] and fence_req[0] asserted together -> two full sequences, ack[0] first then ack[3], two separate wmb_flush pulses.
REQ-036 wmb_busy=0 throughout, fence_req[1] with empty register -> DRAIN, FLUSH, WAIT, ACK; fence_ack[1] pulses at cycle 4 after the request.
REQ-037 rst asserted during WAIT -> no fence_ack; all outputs zero the next cycle; FSM IDLE.
